// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-port memory responder with programmable access latency
//
// Purpose: accepts one word request at a time from the core MEM stage, waits
// LATENCY cycles, then commits the write or returns read data with a one-cycle
// resp_valid pulse. busy stalls the pipeline while a request is outstanding.
// A back-door port preloads storage in any state.
//
// Ports:
//   clk        - single clock, rising edge
//   reset_n    - synchronous reset, asserted HIGH (name kept from the codebase)
//   req_valid  - request present, held by the requester until accepted
//   req_write  - 1 = write, 0 = read
//   req_addr   - word address (upper bits above the storage index are ignored)
//   req_wdata  - write data
//   req_ready  - responder idle and able to accept
//   resp_valid - one-cycle completion pulse
//   resp_rdata - read data, held until the next read completes
//   busy       - request outstanding
//   init_we    - back-door write enable
//   init_addr  - back-door word address
//   init_data  - back-door write data
module data_mem_responder #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              busy,
   input  logic              init_we,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [DATA_W-1:0] init_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                do_access;
   logic                core_we;
   logic [IDX_W-1:0]    init_idx;

   assign init_idx  = init_addr[IDX_W-1:0];
   // The access happens on the edge that leaves WAIT for RESP.
   assign do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);
   // A commit edge that coincides with reset is dropped.
   assign core_we   = do_access && wr_q && !reset_n;

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is never cleared by reset. The core write is placed after the
   // back-door write so it wins when both target the same index.
   always_ff @(posedge clk) begin
      if (init_we) begin
         mem[init_idx] <= init_data;
      end
      if (core_we) begin
         mem[idx_q] <= wdata_q;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req_valid) state_d = S_WAIT;
         S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: request latch, latency countdown, read capture
   always_comb begin
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (state_q == S_IDLE && req_valid) begin
         wr_d    = req_write;
         idx_d   = req_addr[IDX_W-1:0];
         wdata_d = req_wdata;
         cnt_d   = CNT_LOAD;
      end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
      if (do_access && !wr_q) begin
         rdata_d = mem[idx_q];
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      req_ready  = (state_q == S_IDLE);
      busy       = (state_q != S_IDLE);
      resp_valid = (state_q == S_RESP);
      resp_rdata = rdata_q;
   end

endmodule
